toll_condition_gen: RTL and testbench

Sequential front end for the toll rate classifier: keeps a minute/hour/day-of-week calendar and counts vehicles per time window. From these it produces the four condition bits WD, RH, LN and HT. The rate logic turns those bits into a H/M/L/E rate class. This block sits upstream of that logic and drives its inputs directly. It must never drive LN and RH high together, because that combination is the error class.

---
 rtl/toll_pkg.sv | 44 ++++
 rtl/toll_condition_gen_traffic_window.sv | 61 ++++++
 rtl/toll_condition_gen.sv | 115 +++++++++++
 tb/tb_toll_condition_gen.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toll_pkg.sv
// Shared constants and types for the toll condition generator.
// Calendar field widths, day encoding, rush-hour/late-night bounds, wrap limits.
package toll_pkg;

  localparam int unsigned DAY_W  = 3;
  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;

  localparam logic [DAY_W-1:0] MON = 3'd0;
  localparam logic [DAY_W-1:0] TUE = 3'd1;
  localparam logic [DAY_W-1:0] WED = 3'd2;
  localparam logic [DAY_W-1:0] THU = 3'd3;
  localparam logic [DAY_W-1:0] FRI = 3'd4;
  localparam logic [DAY_W-1:0] SAT = 3'd5;
  localparam logic [DAY_W-1:0] SUN = 3'd6;

  localparam logic [HOUR_W-1:0] RUSH_AM_LO = 5'd7;
  localparam logic [HOUR_W-1:0] RUSH_AM_HI = 5'd9;
  localparam logic [HOUR_W-1:0] RUSH_PM_LO = 5'd16;
  localparam logic [HOUR_W-1:0] RUSH_PM_HI = 5'd18;
  localparam logic [HOUR_W-1:0] NIGHT_LO   = 5'd22;
  localparam logic [HOUR_W-1:0] NIGHT_HI   = 5'd5;

  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [DAY_W-1:0]  DAY_MAX  = SUN;

  typedef struct packed {
    logic [DAY_W-1:0]  day;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
  } cal_t;

  // Rush-hour hour ranges; weekday qualification is applied by the caller.
  function automatic logic is_rush_hour(input logic [HOUR_W-1:0] h);
    return ((h >= RUSH_AM_LO) && (h <= RUSH_AM_HI)) ||
           ((h >= RUSH_PM_LO) && (h <= RUSH_PM_HI));
  endfunction

  function automatic logic is_late_night(input logic [HOUR_W-1:0] h);
    return (h >= NIGHT_LO) || (h <= NIGHT_HI);
  endfunction

endpackage

// File: rtl/toll_condition_gen_traffic_window.sv
// toll_traffic_window: counts cars per WINDOW_MIN-minute window and latches
// HT when a window closes.
// Ports: clk, rst (sync, active-high), tick (minute strobe), car (vehicle
// strobe), HT (registered high-traffic flag for the last completed window).
module toll_traffic_window #(
  parameter int unsigned HT_THRESH  = 20,
  parameter int unsigned WINDOW_MIN = 5,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic car,
  output logic HT
);

  localparam int unsigned WIN_W = $clog2(WINDOW_MIN + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [WIN_W-1:0] win_min_q, win_min_d;
  logic [CNT_W-1:0] car_cnt_q, car_cnt_d;
  logic             ht_q, ht_d;
  logic [SUM_W-1:0] sum_c;
  logic [CNT_W-1:0] cnt_sat_c;

  // One extra bit of headroom exposes the overflow used for saturation.
  assign sum_c     = {1'b0, car_cnt_q} + SUM_W'(car);
  assign cnt_sat_c = sum_c[CNT_W] ? {CNT_W{1'b1}} : sum_c[CNT_W-1:0];

  // Next-state: accumulate cars, close the window on its last tick.
  always_comb begin
    win_min_d = win_min_q;
    car_cnt_d = cnt_sat_c;
    ht_d      = ht_q;
    if (tick) begin
      if (win_min_q == WIN_W'(WINDOW_MIN - 1)) begin
        // A car on the closing tick belongs to the closing window.
        ht_d      = (sum_c >= SUM_W'(HT_THRESH));
        car_cnt_d = '0;
        win_min_d = '0;
      end else begin
        win_min_d = win_min_q + WIN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_min_q <= '0;
      car_cnt_q <= '0;
      ht_q      <= 1'b0;
    end else begin
      win_min_q <= win_min_d;
      car_cnt_q <= car_cnt_d;
      ht_q      <= ht_d;
    end
  end

  assign HT = ht_q;

endmodule

// File: rtl/toll_condition_gen.sv
// toll_condition_gen: minute/hour/day calendar with load checking, and the
// WD/RH/LN/HT condition bits feeding the toll rate classifier.
// Ports: clk, rst (sync, active-high), tick (minute strobe), car (vehicle
// strobe), load + load_day/hour/min (calendar preset), load_err (pulse on
// out-of-range load field), WD/RH/LN/HT (condition bits), day/hour/min
// (current calendar).
module toll_condition_gen
  import toll_pkg::*;
#(
  parameter int unsigned HT_THRESH  = 20,
  parameter int unsigned WINDOW_MIN = 5,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              car,
  input  logic              load,
  input  logic [DAY_W-1:0]  load_day,
  input  logic [HOUR_W-1:0] load_hour,
  input  logic [MIN_W-1:0]  load_min,
  output logic              load_err,
  output logic              WD,
  output logic              RH,
  output logic              LN,
  output logic              HT,
  output logic [DAY_W-1:0]  day,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min
);

  cal_t cal_q, cal_d;
  logic err_q, err_d;
  logic wd_q, wd_d;
  logic rh_q, rh_d;
  logic ln_q, ln_d;
  logic day_ok_c, hour_ok_c, min_ok_c;
  logic win_tick_c;

  assign day_ok_c  = (load_day  <= DAY_MAX);
  assign hour_ok_c = (load_hour <= HOUR_MAX);
  assign min_ok_c  = (load_min  <= MIN_MAX);

  // Calendar next-state: load beats tick; each load field is checked alone.
  always_comb begin
    cal_d = cal_q;
    err_d = 1'b0;
    if (load) begin
      if (day_ok_c)  cal_d.day  = load_day;
      if (hour_ok_c) cal_d.hour = load_hour;
      if (min_ok_c)  cal_d.min  = load_min;
      err_d = ~(day_ok_c & hour_ok_c & min_ok_c);
    end else if (tick) begin
      if (cal_q.min == MIN_MAX) begin
        cal_d.min = '0;
        if (cal_q.hour == HOUR_MAX) begin
          cal_d.hour = '0;
          cal_d.day  = (cal_q.day == DAY_MAX) ? MON : cal_q.day + DAY_W'(1);
        end else begin
          cal_d.hour = cal_q.hour + HOUR_W'(1);
        end
      end else begin
        cal_d.min = cal_q.min + MIN_W'(1);
      end
    end
  end

  // Condition decode from the registered calendar; RH and LN hour ranges
  // do not overlap, so the error rate class can never be produced.
  always_comb begin
    wd_d = (cal_q.day <= FRI);
    rh_d = wd_d & is_rush_hour(cal_q.hour);
    ln_d = is_late_night(cal_q.hour);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cal_q <= '0;
      err_q <= 1'b0;
      wd_q  <= 1'b0;
      rh_q  <= 1'b0;
      ln_q  <= 1'b0;
    end else begin
      cal_q <= cal_d;
      err_q <= err_d;
      wd_q  <= wd_d;
      rh_q  <= rh_d;
      ln_q  <= ln_d;
    end
  end

  // A tick swallowed by a load does not advance the traffic window either.
  assign win_tick_c = tick & ~load;

  toll_traffic_window #(
    .HT_THRESH (HT_THRESH),
    .WINDOW_MIN(WINDOW_MIN),
    .CNT_W     (CNT_W)
  ) u_window (
    .clk (clk),
    .rst (rst),
    .tick(win_tick_c),
    .car (car),
    .HT  (HT)
  );

  assign load_err = err_q;
  assign WD       = wd_q;
  assign RH       = rh_q;
  assign LN       = ln_q;
  assign day      = cal_q.day;
  assign hour     = cal_q.hour;
  assign min      = cal_q.min;

endmodule

// File: tb/tb_toll_condition_gen.sv
// Directed self-checking bench for toll_condition_gen.
module tb_toll_condition_gen;

  logic       clk = 1'b0;
  logic       rst, tick, car, load;
  logic [2:0] load_day;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic       load_err, WD, RH, LN, HT;
  logic [2:0] day;
  logic [4:0] hour;
  logic [5:0] min;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  toll_condition_gen #(
    .HT_THRESH (20),
    .WINDOW_MIN(5),
    .CNT_W     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .car      (car),
    .load     (load),
    .load_day (load_day),
    .load_hour(load_hour),
    .load_min (load_min),
    .load_err (load_err),
    .WD       (WD),
    .RH       (RH),
    .LN       (LN),
    .HT       (HT),
    .day      (day),
    .hour     (hour),
    .min      (min)
  );

  // Reference decode {WD,RH,LN} written directly from the hour/day ranges.
  function automatic logic [2:0] ref_dec(input logic [2:0] d, input logic [4:0] h);
    logic wd, rh, ln;
    wd = (d <= 3'd4);
    rh = wd && (((h >= 5'd7) && (h <= 5'd9)) || ((h >= 5'd16) && (h <= 5'd18)));
    ln = (h >= 5'd22) || (h <= 5'd5);
    return {wd, rh, ln};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; car = 1'b0; load = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] d, input logic [4:0] h, input logic [5:0] m);
    load = 1'b1; load_day = d; load_hour = h; load_min = m;
    step();
    load = 1'b0;
  endtask

  // Spread `total` cars across five ticks (up to four per gap), optional car on the closing tick.
  task automatic run_window(input int total, input logic close_car);
    int left;
    int n;
    left = total;
    for (int t = 0; t < 5; t++) begin
      n = (t == 4) ? left : ((left < 4) ? left : 4);
      left -= n;
      for (int c = 0; c < n; c++) begin
        car = 1'b1;
        step();
      end
      car  = (t == 4) ? close_car : 1'b0;
      tick = 1'b1;
      step();
      tick = 1'b0;
      car  = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; car = 1'b0; load = 1'b0;
    load_day = '0; load_hour = '0; load_min = '0;
    step();
    step();
    checks++;
    if ({day, hour, min} !== 14'd0) begin
      errors++; $display("FAIL reset_cal got %h exp %h", {day, hour, min}, 14'd0);
    end
    checks++;
    if ({WD, RH, LN, HT, load_err} !== 5'b00000) begin
      errors++; $display("FAIL reset_flags got %b exp %b", {WD, RH, LN, HT, load_err}, 5'b00000);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({WD, RH, LN} !== 3'b101) begin
      errors++; $display("FAIL post_reset_decode got %b exp %b", {WD, RH, LN}, 3'b101);
    end
  endtask

  task automatic test_load_rush();
    do_load(3'd0, 5'd8, 6'd30);
    checks++;
    if ({day, hour, min} !== {3'd0, 5'd8, 6'd30}) begin
      errors++; $display("FAIL load_mon0830 got %h exp %h", {day, hour, min}, {3'd0, 5'd8, 6'd30});
    end
    checks++;
    if (load_err !== 1'b0) begin
      errors++; $display("FAIL load_mon0830_err got %b exp 0", load_err);
    end
    step();
    checks++;
    if ({WD, RH, LN} !== 3'b110) begin
      errors++; $display("FAIL rush_decode got %b exp %b", {WD, RH, LN}, 3'b110);
    end
  endtask

  task automatic test_calendar_wrap();
    do_load(3'd4, 5'd23, 6'd59);
    tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if ({day, hour, min} !== {3'd5, 5'd0, 6'd0}) begin
      errors++; $display("FAIL fri_to_sat got %h exp %h", {day, hour, min}, {3'd5, 5'd0, 6'd0});
    end
    step();
    checks++;
    if ({WD, RH, LN} !== 3'b001) begin
      errors++; $display("FAIL sat_decode got %b exp %b", {WD, RH, LN}, 3'b001);
    end
    do_load(3'd6, 5'd23, 6'd59);
    tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if ({day, hour, min} !== 14'd0) begin
      errors++; $display("FAIL sun_to_mon got %h exp %h", {day, hour, min}, 14'd0);
    end
  endtask

  task automatic test_traffic();
    do_reset();
    run_window(19, 1'b0);
    checks++;
    if (HT !== 1'b0) begin errors++; $display("FAIL win1_19cars got %b exp 0", HT); end
    run_window(19, 1'b1);
    checks++;
    if (HT !== 1'b1) begin errors++; $display("FAIL win2_20cars got %b exp 1", HT); end
    run_window(0, 1'b0);
    checks++;
    if (HT !== 1'b0) begin errors++; $display("FAIL win3_0cars got %b exp 0", HT); end
    // 260 cars: a wrapping 8-bit counter would read 4, a saturating one 255.
    run_window(260, 1'b0);
    checks++;
    if (HT !== 1'b1) begin errors++; $display("FAIL win_saturate got %b exp 1", HT); end
    run_window(0, 1'b0);
    checks++;
    if (HT !== 1'b0) begin errors++; $display("FAIL win_after_sat got %b exp 0", HT); end
  endtask

  task automatic test_load_err();
    do_load(3'd1, 5'd13, 6'd45);
    checks++;
    if ({day, hour, min} !== {3'd1, 5'd13, 6'd45}) begin
      errors++; $display("FAIL preload got %h exp %h", {day, hour, min}, {3'd1, 5'd13, 6'd45});
    end
    do_load(3'd2, 5'd24, 6'd10);
    checks++;
    if ({day, hour, min} !== {3'd2, 5'd13, 6'd10}) begin
      errors++; $display("FAIL bad_hour_load got %h exp %h", {day, hour, min}, {3'd2, 5'd13, 6'd10});
    end
    checks++;
    if (load_err !== 1'b1) begin errors++; $display("FAIL load_err_pulse got %b exp 1", load_err); end
    step();
    checks++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL load_err_clear got %b exp 0", load_err); end
    do_load(3'd7, 5'd5, 6'd60);
    checks++;
    if ({day, hour, min} !== {3'd2, 5'd5, 6'd10}) begin
      errors++; $display("FAIL bad_day_min_load got %h exp %h", {day, hour, min}, {3'd2, 5'd5, 6'd10});
    end
    checks++;
    if (load_err !== 1'b1) begin errors++; $display("FAIL load_err_pulse2 got %b exp 1", load_err); end
  endtask

  task automatic test_load_tick();
    tick = 1'b1;
    do_load(3'd3, 5'd10, 6'd20);
    tick = 1'b0;
    checks++;
    if ({day, hour, min} !== {3'd3, 5'd10, 6'd20}) begin
      errors++; $display("FAIL load_vs_tick got %h exp %h", {day, hour, min}, {3'd3, 5'd10, 6'd20});
    end
    tick = 1'b1; step(); tick = 1'b0;
    checks++;
    if ({day, hour, min} !== {3'd3, 5'd10, 6'd21}) begin
      errors++; $display("FAIL tick_after_load got %h exp %h", {day, hour, min}, {3'd3, 5'd10, 6'd21});
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int c = 0; c < 15; c++) begin car = 1'b1; step(); end
    car = 1'b0;
    tick = 1'b1; step(); step(); tick = 1'b0;
    // rst must win over a coincident car, tick and load.
    rst = 1'b1; car = 1'b1; tick = 1'b1;
    load = 1'b1; load_day = 3'd2; load_hour = 5'd8; load_min = 6'd8;
    step();
    rst = 1'b0; car = 1'b0; tick = 1'b0; load = 1'b0;
    checks++;
    if ({day, hour, min} !== 14'd0) begin
      errors++; $display("FAIL rst_over_load got %h exp %h", {day, hour, min}, 14'd0);
    end
    run_window(5, 1'b0);
    checks++;
    if (HT !== 1'b0) begin errors++; $display("FAIL rst_discards_count got %b exp 0", HT); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 20; c++) begin car = 1'b1; step(); end
    car = 1'b0;
    tick = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step();
      if (t == 3) begin
        checks++;
        if (HT !== 1'b0) begin errors++; $display("FAIL b2b_before_close got %b exp 0", HT); end
      end
    end
    tick = 1'b0;
    checks++;
    if (HT !== 1'b1) begin errors++; $display("FAIL b2b_close got %b exp 1", HT); end
    checks++;
    if ({day, hour, min} !== {3'd0, 5'd0, 6'd5}) begin
      errors++; $display("FAIL b2b_minutes got %h exp %h", {day, hour, min}, {3'd0, 5'd0, 6'd5});
    end
  endtask

  task automatic test_week_sweep();
    logic [2:0] md, pd;
    logic [4:0] mh, ph;
    logic [5:0] mm;
    do_reset();
    md = 3'd0; mh = 5'd0; mm = 6'd0;
    tick = 1'b1;
    for (int i = 0; i < 10080; i++) begin
      pd = md; ph = mh;
      step();
      if (mm == 6'd59) begin
        mm = 6'd0;
        if (mh == 5'd23) begin
          mh = 5'd0;
          md = (md == 3'd6) ? 3'd0 : md + 3'd1;
        end else begin
          mh = mh + 5'd1;
        end
      end else begin
        mm = mm + 6'd1;
      end
      checks++;
      if ({day, hour, min} !== {md, mh, mm}) begin
        errors++; $display("FAIL sweep_cal i=%0d got %h exp %h", i, {day, hour, min}, {md, mh, mm});
      end
      checks++;
      if ({WD, RH, LN} !== ref_dec(pd, ph)) begin
        errors++; $display("FAIL sweep_decode i=%0d got %b exp %b", i, {WD, RH, LN}, ref_dec(pd, ph));
      end
      checks++;
      if ((LN & RH) || (RH && (pd >= 3'd5))) begin
        errors++; $display("FAIL sweep_invariant i=%0d got LN=%b RH=%b day=%0d exp no LN&RH, no weekend RH", i, LN, RH, pd);
      end
    end
    tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_rush();
    test_calendar_wrap();
    test_traffic();
    test_load_err();
    test_load_tick();
    test_rst_mid();
    test_back_to_back();
    test_week_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
